mem_store: RTL and testbench
============================

Name: mem_store

Overview:
- Synchronous 32x8 storage block. It sits directly downstream of the memory test bench, on the mem_intf read/write/addr/data path.
- Services single-cycle write and registered-read requests.
- Adds a hardware clear sequencer that zeroes every location.
- Flags illegal request combinations so the bench can check read/write exclusivity on the bus.

Parameters:
ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH (32 locations)
DATA_WIDTH, 8, data word width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
read  input  1  read request, sampled each cycle
write  input  1  write request, sampled each cycle
addr  input  ADDR_WIDTH  request address
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  registered read data
rd_valid  output  1  one-cycle pulse: data_out updated this cycle
clear_start  input  1  pulse: start clear sweep
busy  output  1  high while clear sweep in progress
err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset (rst=1 at a clock edge) drives:
  - data_out=0, rd_valid=0, busy=0, err=0, state=IDLE, clear counter=0.
  - Array contents are NOT reset.
- FSM has two states, IDLE and CLEAR.
- IDLE, write=1 and read=0:
  - mem[addr]<=data_in at the edge.
  - data_out unchanged; rd_valid=0.
- IDLE, read=1 and write=0:
  - The edge loads data_out<=mem[addr] and sets rd_valid=1 for exactly one cycle.
  - Latency is 1 cycle: the value is visible in the cycle after the request.
- Back-to-back reads produce a rd_valid pulse every cycle, each with its own address's data.
- Write to A in cycle n, read of A in cycle n+1: data_out in n+2 returns the new data (no stale read).
- read=1 and write=1 in the same cycle:
  - No array access; data_out holds; rd_valid=0.
  - err=1 in the next cycle.
- IDLE, clear_start=1:
  - Enter CLEAR; busy=1 from the next cycle.
  - Any read/write in the same cycle is dropped and err pulses.
- CLEAR sweep:
  - Each cycle writes 0 to mem[cnt], then cnt increments, for cnt=0..31 (32 cycles).
  - After the write of location 31 the state returns to IDLE and busy=0 the following cycle.
  - busy is high for exactly 32 cycles.
- In CLEAR:
  - read or write requests are ignored: no array access, rd_valid=0, err pulses once per ignored request cycle.
  - clear_start is ignored with no err.
- The counter is ADDR_WIDTH bits; wrap 31->0 coincides with the exit to IDLE, and there is no second sweep.
- rst mid-CLEAR:
  - Sweep aborts; busy=0 next cycle.
  - Locations already cleared remain 0; the rest keep their prior contents.
- err and rd_valid are never high in the same cycle.

Test Plan:
1. rst, clear_start pulse -> busy high exactly 32 cycles; then read addr 0..31 -> every rd_valid pulse carries data_out=8'h00.
2. write addr=i, data=i for i=0..31, then read 0..31 -> data_out=i one cycle after each read; rd_valid asserted on each return cycle.
3. write addr=5 data=8'hA5, next cycle read addr=5 -> data_out=8'hA5 with rd_valid=1 two cycles after the write.
4. read=1 and write=1, addr=3, data_in=8'hFF (location 3 holds 8'h03) -> err=1 next cycle, rd_valid=0; subsequent read of addr 3 returns 8'h03.
5. Fill 8'h55 everywhere; clear_start; assert rst in the 10th busy cycle -> busy=0 next cycle; addr 0..8 read 8'h00, addr 9..31 read 8'h55.
6. During CLEAR, issue read addr=7 for 3 cycles and a second clear_start -> err pulses 3 times, no rd_valid, busy still ends after 32 cycles total.

Source files
------------

// File: rtl/mem_store.sv
// 32x8 storage with 1-cycle registered read and a hardware clear sweep that zeroes every location.
// Illegal request combinations (read+write, requests during or alongside a clear) are dropped and flagged on err.
module mem_store #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    rd_valid_q;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    rd_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          // A request that arrives alongside clear_start is dropped, not serviced.
          state_d = CLEAR;
          cnt_d   = '0;
          err_d   = read | write;
        end else if (read && write) begin
          err_d = 1'b1;
        end else if (write) begin
          mem_we = 1'b1;
        end else if (read) begin
          rd_en = 1'b1;
        end
      end

      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        err_d     = read | write;
        // Last location written: counter wraps to 0 as the sweep ends.
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_en;
      err_q      <= err_d;
      if (rd_en) begin
        data_out_q <= mem[addr];
      end
    end
  end

  // Array is not reset, but reset must still suppress any write in its cycle so an aborted sweep stops cleanly.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_mem_store.sv
// Directed bench for mem_store: vector table for single-cycle behaviour plus hand-written clear/reset sequences.
module tb_mem_store;

  logic       clk;
  logic       rst;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       clear_start;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  mem_store #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .read        (read),
    .write       (write),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .clear_start (clear_start),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic       clr;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] e_dout;
    logic       e_vld;
    logic       e_err;
    logic       e_busy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumes them.
  task automatic step(input logic r, input logic w, input logic c, input logic rs,
                      input logic [4:0] a, input logic [7:0] d);
    read        = r;
    write       = w;
    clear_start = c;
    rst         = rs;
    addr        = a;
    data_in     = d;
    @(posedge clk);
    #1;
    read        = 1'b0;
    write       = 1'b0;
    clear_start = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  // Run idle cycles until busy drops; returns how many sampled cycles still showed busy.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      idle();
      if (busy) n++;
    end
  endtask

  initial begin
    int n;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 5'd5, 8'hA5, 8'h1F, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd5, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 5'd3, 8'hFF, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'd3, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 5'd0, 8'h7E, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 8'h7E, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 5'd2, 8'h00, 8'h7E, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'd7, 8'h00, 8'h7E, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 5'd7, 8'h00, 8'h7E, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'd7, 8'h00, 8'h7E, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 8'h7E, 1'b0, 1'b0, 1'b1};

    read = 1'b0; write = 1'b0; clear_start = 1'b0; rst = 1'b1;
    addr = '0; data_in = '0;

    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_vld", rd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);

    // Full clear sweep, then every location reads zero.
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
    chk("clr_busy_first", busy, 1'b1);
    count_busy(n);
    chk("clr_busy_len", n + 1, 32);
    chk("clr_busy_done", busy, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'(i), 8'h00);
      chk("clr_rd_vld", rd_valid, 1'b1);
      chk("clr_rd_dat", data_out, 8'h00);
    end

    // Write i to each location, then read back back-to-back.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 5'(i), 8'(i));
      chk("wr_vld", rd_valid, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'(i), 8'h00);
      chk("rd_vld", rd_valid, 1'b1);
      chk("rd_dat", data_out, 8'(i));
      chk("rd_err", err, 1'b0);
    end

    // Vector table: write-then-read, read+write collision, clear entry with requests, requests during clear.
    for (int v = 0; v < 13; v++) begin
      step(tbl[v].rd, tbl[v].wr, tbl[v].clr, 1'b0, tbl[v].a, tbl[v].d);
      chk($sformatf("vec%0d_dout", v), data_out, tbl[v].e_dout);
      chk($sformatf("vec%0d_vld", v), rd_valid, tbl[v].e_vld);
      chk($sformatf("vec%0d_err", v), err, tbl[v].e_err);
      chk($sformatf("vec%0d_busy", v), busy, tbl[v].e_busy);
    end
    // Five busy cycles already observed by the table; the second clear_start must not extend the sweep.
    count_busy(n);
    chk("clr2_busy_len", n + 5, 32);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    chk("clr2_rd0", data_out, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 8'h00);
    chk("clr2_rd7", data_out, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 8'h00);
    chk("clr2_rd31", data_out, 8'h00);

    // Fill 0x55, start a clear, reset in the 10th busy cycle.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 5'(i), 8'h55);
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 8; i++) idle();
    idle();
    chk("abort_busy_pre", busy, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_dout", data_out, 8'h00);
    idle();
    chk("abort_stays_idle", busy, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'(i), 8'h00);
      chk("abort_rd_vld", rd_valid, 1'b1);
      chk($sformatf("abort_rd%0d", i), data_out, (i <= 8) ? 8'h00 : 8'h55);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // rd_valid and err are mutually exclusive at every sampled point.
  always @(negedge clk) begin
    if (rd_valid && err) begin
      bad++;
      $display("FAIL vld_err_excl: rd_valid=%0b err=%0b required not both", rd_valid, err);
    end
  end

endmodule
